// File: rtl/fetch_inst_queue_if.sv
// Fetch-to-decode instruction queue bundle: fetch push port, issue pop port, two decode slots.
// master = fetch/issue side, slave = the queue.
interface fetch_inst_queue_if #(
   parameter int CNT_W = 4
);
   logic             push_valid;
   logic [31:0]      push_pc;
   logic [63:0]      push_inst;
   logic             push_ready;
   logic [1:0]       pop_cnt;
   logic             out0_valid;
   logic [31:0]      out0_inst;
   logic [31:0]      out0_pc;
   logic             out1_valid;
   logic [31:0]      out1_inst;
   logic [31:0]      out1_pc;
   logic [CNT_W-1:0] count;

   modport master (
      output push_valid, push_pc, push_inst, pop_cnt,
      input  push_ready, out0_valid, out0_inst, out0_pc,
      input  out1_valid, out1_inst, out1_pc, count
   );

   modport slave (
      input  push_valid, push_pc, push_inst, pop_cnt,
      output push_ready, out0_valid, out0_inst, out0_pc,
      output out1_valid, out1_inst, out1_pc, count
   );
endinterface

// File: rtl/fetch_inst_queue.sv
// Dual-issue instruction queue: 2-wide push from fetch, 0/1/2-wide pop into decode, flush on redirect.
// Optional INSTQ_MISALIGN_EN: a packet whose PC points at the odd word enqueues only the upper instruction.
module fetch_inst_queue #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 4
) (
   input logic                clk,
   input logic                reset,
   input logic                flush,
   fetch_inst_queue_if.slave  q
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]      inst_mem [DEPTH];
   logic [31:0]      pc_mem   [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [PTR_W-1:0] rd_ptr_p1, wr_ptr_p1;
   logic [CNT_W-1:0] count_q;

   logic       push_go;
   logic [1:0] push_n;
   logic [1:0] pop_req;
   logic [1:0] eff_pop;
   logic [1:0] wr_en;
   logic [31:0] wr_inst0, wr_pc0, wr_inst1, wr_pc1;

   assign rd_ptr_p1 = rd_ptr + PTR_W'(1);
   assign wr_ptr_p1 = wr_ptr + PTR_W'(1);

   // Ready looks only at the registered count; a pop in the same cycle is not credited.
   assign q.push_ready = (count_q <= CNT_W'(DEPTH - 2));
   assign push_go      = q.push_valid && q.push_ready && !reset && !flush;

   assign pop_req = (q.pop_cnt == 2'd3) ? 2'd2 : q.pop_cnt;
   assign eff_pop = (count_q < CNT_W'(pop_req)) ? count_q[1:0] : pop_req;

   always_comb begin
      wr_en    = 2'b00;
      push_n   = 2'd0;
      wr_inst0 = q.push_inst[31:0];
      wr_pc0   = q.push_pc & ~32'h7;
      wr_inst1 = q.push_inst[63:32];
      wr_pc1   = (q.push_pc & ~32'h7) + 32'd4;
`ifdef INSTQ_MISALIGN_EN
      if (q.push_pc[2]) begin
         wr_inst0 = q.push_inst[63:32];
         wr_pc0   = q.push_pc;
         if (push_go) begin
            wr_en  = 2'b01;
            push_n = 2'd1;
         end
      end else if (push_go) begin
         wr_en  = 2'b11;
         push_n = 2'd2;
      end
`else
      if (push_go) begin
         wr_en  = 2'b11;
         push_n = 2'd2;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         rd_ptr  <= rd_ptr + PTR_W'(eff_pop);
         wr_ptr  <= wr_ptr + PTR_W'(push_n);
         count_q <= count_q + CNT_W'(push_n) - CNT_W'(eff_pop);
      end
   end

   // Storage is never cleared; validity comes from count alone.
   always_ff @(posedge clk) begin
      if (wr_en[0]) begin
         inst_mem[wr_ptr] <= wr_inst0;
         pc_mem[wr_ptr]   <= wr_pc0;
      end
      if (wr_en[1]) begin
         inst_mem[wr_ptr_p1] <= wr_inst1;
         pc_mem[wr_ptr_p1]   <= wr_pc1;
      end
   end

   assign q.count      = count_q;
   assign q.out0_valid = (count_q != '0);
   assign q.out1_valid = (count_q >= CNT_W'(2));
   assign q.out0_inst  = q.out0_valid ? inst_mem[rd_ptr]    : NOP;
   assign q.out0_pc    = q.out0_valid ? pc_mem[rd_ptr]      : 32'h0;
   assign q.out1_inst  = q.out1_valid ? inst_mem[rd_ptr_p1] : NOP;
   assign q.out1_pc    = q.out1_valid ? pc_mem[rd_ptr_p1]   : 32'h0;
endmodule

// File: tb/tb_fetch_inst_queue.sv
// Bench for fetch_inst_queue: queue-based reference model checked every cycle, plus directed literal checks.
// Build with or without INSTQ_MISALIGN_EN; the model follows the same macro.
module tb_fetch_inst_queue;
   localparam int DEPTH = 8;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic reset;
   logic flush;
   logic chk_en = 1'b0;
   logic log_en = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [63:0] mq [$];
   logic [31:0] out_log [$];

   fetch_inst_queue_if #(.CNT_W(CNT_W)) qif ();

   fetch_inst_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .q     (qif)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: a queue of {inst,pc}, updated with the sampled inputs at each edge.
   always @(posedge clk) begin
      int  n;
      bit  acc;
      acc = qif.push_valid && (mq.size() <= DEPTH - 2);
      if (reset || flush) begin
         mq.delete();
      end else begin
         n = (qif.pop_cnt >= 2) ? 2 : int'(qif.pop_cnt);
         if (n > mq.size()) n = mq.size();
         for (int i = 0; i < n; i++) void'(mq.pop_front());
         if (acc) begin
`ifdef INSTQ_MISALIGN_EN
            if (qif.push_pc[2]) begin
               mq.push_back({qif.push_inst[63:32], qif.push_pc});
            end else begin
               mq.push_back({qif.push_inst[31:0], {qif.push_pc[31:3], 3'b000}});
               mq.push_back({qif.push_inst[63:32], {qif.push_pc[31:3], 3'b100}});
            end
`else
            mq.push_back({qif.push_inst[31:0], {qif.push_pc[31:3], 3'b000}});
            mq.push_back({qif.push_inst[63:32], {qif.push_pc[31:3], 3'b100}});
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic [63:0] e0, e1;
         e0 = (mq.size() >= 1) ? mq[0] : {32'h0000_0013, 32'h0};
         e1 = (mq.size() >= 2) ? mq[1] : {32'h0000_0013, 32'h0};
         check("m_count", 32'(qif.count), 32'(mq.size()));
         check("m_ready", 32'(qif.push_ready), 32'(mq.size() <= DEPTH - 2));
         check("m_v0", 32'(qif.out0_valid), 32'(mq.size() >= 1));
         check("m_v1", 32'(qif.out1_valid), 32'(mq.size() >= 2));
         check("m_i0", qif.out0_inst, e0[63:32]);
         check("m_p0", qif.out0_pc, e0[31:0]);
         check("m_i1", qif.out1_inst, e1[63:32]);
         check("m_p1", qif.out1_pc, e1[31:0]);
      end
      if (log_en) begin
         if (qif.pop_cnt >= 1 && qif.out0_valid) out_log.push_back(qif.out0_inst);
         if (qif.pop_cnt >= 2 && qif.out1_valid) out_log.push_back(qif.out1_inst);
      end
   end

   task automatic step(input logic pv, input logic [31:0] pc, input logic [63:0] inst,
                       input logic [1:0] pop, input logic fl);
      qif.push_valid = pv;
      qif.push_pc    = pc;
      qif.push_inst  = inst;
      qif.pop_cnt    = pop;
      flush          = fl;
      @(posedge clk);
      #1;
      qif.push_valid = 1'b0;
      qif.pop_cnt    = 2'd0;
      flush          = 1'b0;
   endtask

   function automatic logic [31:0] ai(input int k);
      return 32'hA000_0000 + 32'(k);
   endfunction

   initial begin
      reset          = 1'b1;
      flush          = 1'b0;
      qif.push_valid = 1'b0;
      qif.push_pc    = 32'h0;
      qif.push_inst  = 64'h0;
      qif.pop_cnt    = 2'd0;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      reset  = 1'b0;
      chk_en = 1'b1;

      // 1: reset state, then first packet
      check("rst_count", 32'(qif.count), 0);
      check("rst_v0", 32'(qif.out0_valid), 0);
      check("rst_ready", 32'(qif.push_ready), 1);
      check("rst_i0", qif.out0_inst, 32'h0000_0013);
      step(1, 32'h100, {ai(1), ai(0)}, 0, 0);
      check("t1_i0", qif.out0_inst, ai(0));
      check("t1_p0", qif.out0_pc, 32'h100);
      check("t1_i1", qif.out1_inst, ai(1));
      check("t1_p1", qif.out1_pc, 32'h104);
      check("t1_count", 32'(qif.count), 2);

      // 2: fill to DEPTH, then an extra push is refused
      for (int k = 1; k < 4; k++)
         step(1, 32'h100 + 32'(8 * k), {ai(2 * k + 1), ai(2 * k)}, 0, 0);
      check("t2_count", 32'(qif.count), 8);
      check("t2_ready", 32'(qif.push_ready), 0);
      step(1, 32'h120, {ai(9), ai(8)}, 0, 0);
      check("t2_hold", 32'(qif.count), 8);

      // 3: full with push + pop 2: push rejected
      step(1, 32'h128, {ai(11), ai(10)}, 2, 0);
      check("t3_count", 32'(qif.count), 6);
      check("t3_i0", qif.out0_inst, ai(2));
      check("t3_p0", qif.out0_pc, 32'h108);

      // 4: drain down to one, then over-pop
      step(0, 0, 0, 2, 0);
      step(0, 0, 0, 2, 0);
      step(0, 0, 0, 1, 0);
      check("t4_one", 32'(qif.count), 1);
      check("t4_i0", qif.out0_inst, ai(7));
      check("t4_p0", qif.out0_pc, 32'h11C);
      step(0, 0, 0, 3, 0);
      check("t4_count", 32'(qif.count), 0);
      check("t4_v0", 32'(qif.out0_valid), 0);
      check("t4_nop", qif.out0_inst, 32'h0000_0013);
      check("t4_pc", qif.out0_pc, 0);

      // 5: flush beats simultaneous push and pop
      for (int k = 0; k < 3; k++)
         step(1, 32'h300 + 32'(8 * k), {ai(21 + 2 * k), ai(20 + 2 * k)}, 0, 0);
      check("t5_pre", 32'(qif.count), 6);
      step(1, 32'h318, {ai(27), ai(26)}, 1, 1);
      check("t5_count", 32'(qif.count), 0);
      check("t5_v0", 32'(qif.out0_valid), 0);
      check("t5_v1", 32'(qif.out1_valid), 0);
      check("t5_ready", 32'(qif.push_ready), 1);

      // 6: push to an odd-word PC
      step(1, 32'h204, {32'hC000_0001, 32'hC000_0000}, 0, 0);
`ifdef INSTQ_MISALIGN_EN
      check("t6_count", 32'(qif.count), 1);
      check("t6_i0", qif.out0_inst, 32'hC000_0001);
      check("t6_p0", qif.out0_pc, 32'h204);
`else
      check("t6_count", 32'(qif.count), 2);
      check("t6_i0", qif.out0_inst, 32'hC000_0000);
      check("t6_p0", qif.out0_pc, 32'h200);
      check("t6_p1", qif.out1_pc, 32'h204);
`endif
      step(0, 0, 0, 0, 1);

      // 7: streaming through the wrap point
      log_en = 1'b1;
      for (int k = 0; k < 20; k++)
         step(1, 32'h1000 + 32'(8 * k), {32'hB000_0000 + 32'(2 * k + 1), 32'hB000_0000 + 32'(2 * k)}, 2, 0);
      step(0, 0, 0, 2, 0);
      log_en = 1'b0;
      check("t7_count", 32'(qif.count), 0);
      check("t7_len", 32'(out_log.size()), 40);
      for (int j = 0; j < 40 && j < out_log.size(); j++)
         check("t7_order", out_log[j], 32'hB000_0000 + 32'(j));

      // reset takes priority over everything else in flight
      step(1, 32'h400, {ai(31), ai(30)}, 0, 0);
      reset = 1'b1;
      step(1, 32'h408, {ai(33), ai(32)}, 0, 0);
      reset = 1'b0;
      check("rst2_count", 32'(qif.count), 0);
      step(0, 0, 0, 0, 0);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
